// File: rtl/cond_status_unit_pkg.sv
// Shared definitions for the condition/status unit: ARM condition-code
// encodings and the bit positions of the flags inside the {Z,C,N,V} nibble.
package cond_status_unit_pkg;

    // Four-bit ARM condition field encodings; 1111 is reserved and never passes
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Flag positions inside the status nibble
    localparam int Z_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/cond_status_unit_cond_eval.sv
// Purely combinational evaluation of one ARM condition field against a set
// of {Z,C,N,V} flags. One instance per lane.
module cond_eval
    import cond_status_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_z;
    logic w_c;
    logic w_n;
    logic w_v;

    assign w_z = i_flags[Z_BIT];
    assign w_c = i_flags[C_BIT];
    assign w_n = i_flags[N_BIT];
    assign w_v = i_flags[V_BIT];

    // Decode the condition field into a pass/fail decision
    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_status_unit.sv
// Multi-lane condition/status unit. Owns the NZCV status register, evaluates
// one condition field per lane, registers the per-lane execute enables for
// the EXE/MEM boundary and keeps a saturating count of skipped instructions.
module cond_status_unit
    import cond_status_unit_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int BYPASS    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_freeze,
    input  logic                   i_flush,
    input  logic                   i_status_we,
    input  logic [3:0]             i_status_in,
    input  logic [NUM_LANES-1:0]   i_in_valid,
    input  logic [4*NUM_LANES-1:0] i_cond,
    input  logic                   i_count_clr,
    output logic [3:0]             o_status_out,
    output logic [NUM_LANES-1:0]   o_out_valid,
    output logic [NUM_LANES-1:0]   o_exec_en,
    output logic [CNT_W-1:0]       o_skip_count
);

    // Saturation ceiling, widened so the sum below can exceed it without wrapping
    localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

    logic [3:0]           r_status;
    logic [NUM_LANES-1:0] r_outValid;
    logic [NUM_LANES-1:0] r_execEn;
    logic [CNT_W-1:0]     r_skipCount;

    logic [3:0]           w_evalFlags;
    logic [NUM_LANES-1:0] w_pass;
    logic [NUM_LANES-1:0] w_fail;
    logic [2:0]           w_failCount;
    logic [CNT_W+2:0]     w_sum;
    logic [CNT_W-1:0]     w_nextCount;
    logic                 w_accept;

    // With bypass enabled a same-cycle flag write is visible to evaluation
    assign w_evalFlags = ((BYPASS != 0) && i_status_we) ? i_status_in : r_status;

    // Only cycles that are neither flushed nor stalled advance the pipeline
    assign w_accept = !i_flush && !i_freeze;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        cond_eval u_cond_eval (
            .i_cond  (i_cond[4*g +: 4]),
            .i_flags (w_evalFlags),
            .o_pass  (w_pass[g])
        );
    end

    assign w_fail = i_in_valid & ~w_pass;

    // Count the valid lanes whose condition failed this cycle
    always_comb begin
        w_failCount = 3'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_failCount = w_failCount + {2'b00, w_fail[i]};
        end
    end

    assign w_sum       = {3'b000, r_skipCount} + {{CNT_W{1'b0}}, w_failCount};
    assign w_nextCount = (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    // Architectural status register, written from EXE regardless of stall/flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= 4'b0000;
        end else if (i_status_we) begin
            r_status <= i_status_in;
        end
    end

    // Output stage: flush kills, freeze holds, otherwise capture lane results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= '0;
            r_execEn   <= '0;
        end else if (i_flush) begin
            r_outValid <= '0;
            r_execEn   <= '0;
        end else if (!i_freeze) begin
            r_outValid <= i_in_valid;
            r_execEn   <= i_in_valid & w_pass;
        end
    end

    // Saturating skip counter; a clear request beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skipCount <= '0;
        end else if (i_count_clr) begin
            r_skipCount <= '0;
        end else if (w_accept) begin
            r_skipCount <= w_nextCount;
        end
    end

    assign o_status_out = r_status;
    assign o_out_valid  = r_outValid;
    assign o_exec_en    = r_execEn;
    assign o_skip_count = r_skipCount;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed testbench for cond_status_unit. Three instances share one stimulus
// stream: A (BYPASS=1, CNT_W=16), B (BYPASS=0, CNT_W=16), C (BYPASS=1, CNT_W=4).
module tb_cond_status_unit;

    logic       clk;
    logic       rst;
    logic       freeze;
    logic       flush;
    logic       statusWe;
    logic [3:0] statusIn;
    logic [1:0] inValid;
    logic [7:0] cond;
    logic       countClr;

    logic [3:0]  statusOutA, statusOutB, statusOutC;
    logic [1:0]  outValidA, outValidB, outValidC;
    logic [1:0]  execEnA, execEnB, execEnC;
    logic [15:0] skipCountA, skipCountB;
    logic [3:0]  skipCountC;

    int assertCount = 0;
    int failCount   = 0;

    cond_status_unit #(.NUM_LANES(2), .BYPASS(1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .i_freeze(freeze), .i_flush(flush),
        .i_status_we(statusWe), .i_status_in(statusIn), .i_in_valid(inValid),
        .i_cond(cond), .i_count_clr(countClr), .o_status_out(statusOutA),
        .o_out_valid(outValidA), .o_exec_en(execEnA), .o_skip_count(skipCountA)
    );

    cond_status_unit #(.NUM_LANES(2), .BYPASS(0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .i_freeze(freeze), .i_flush(flush),
        .i_status_we(statusWe), .i_status_in(statusIn), .i_in_valid(inValid),
        .i_cond(cond), .i_count_clr(countClr), .o_status_out(statusOutB),
        .o_out_valid(outValidB), .o_exec_en(execEnB), .o_skip_count(skipCountB)
    );

    cond_status_unit #(.NUM_LANES(2), .BYPASS(1), .CNT_W(4)) dutC (
        .clk(clk), .rst(rst), .i_freeze(freeze), .i_flush(flush),
        .i_status_we(statusWe), .i_status_in(statusIn), .i_in_valid(inValid),
        .i_cond(cond), .i_count_clr(countClr), .o_status_out(statusOutC),
        .o_out_valid(outValidC), .o_exec_en(execEnC), .o_skip_count(skipCountC)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        freeze   = 1'b0;
        flush    = 1'b0;
        statusWe = 1'b0;
        statusIn = 4'b0000;
        inValid  = 2'b00;
        cond     = 8'h00;
        countClr = 1'b0;
    endtask

    task automatic test_reset();
        setIdle();
        rst      = 1'b1;
        statusWe = 1'b1;
        statusIn = 4'b1111;
        inValid  = 2'b11;
        cond     = 8'hFF;
        tick();
        tick();
        rst = 1'b0;
        setIdle();
        assertCount++;
        if (statusOutA !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_status: got %b, expected 0000", statusOutA);
        end
        assertCount++;
        if (outValidA !== 2'b00 || execEnA !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got valid=%b exec=%b, expected 00/00", outValidA, execEnA);
        end
        assertCount++;
        if (skipCountA !== 16'd0 || skipCountC !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL reset_count: got A=%0d C=%0d, expected 0/0", skipCountA, skipCountC);
        end
    endtask

    task automatic test_basic();
        statusWe = 1'b1;
        statusIn = 4'b0100;
        tick();
        assertCount++;
        if (statusOutA !== 4'b0100) begin
            failCount++;
            $display("[TB] FAIL basic_status: got %b, expected 0100", statusOutA);
        end
        statusWe = 1'b0;
        inValid  = 2'b01;
        cond     = {4'b0000, 4'b0010};
        tick();
        setIdle();
        assertCount++;
        if (execEnA !== 2'b01 || outValidA !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL basic_cs: got valid=%b exec=%b, expected 01/01", outValidA, execEnA);
        end
        assertCount++;
        if (skipCountA !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL basic_count: got %0d, expected 0", skipCountA);
        end
    endtask

    task automatic test_bypass();
        statusWe = 1'b1;
        statusIn = 4'b0000;
        tick();
        statusIn = 4'b1000;
        inValid  = 2'b01;
        cond     = {4'b0000, 4'b0000};
        tick();
        setIdle();
        assertCount++;
        if (execEnA[0] !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL bypass_on_exec: got %b, expected 1", execEnA[0]);
        end
        assertCount++;
        if (execEnB[0] !== 1'b0 || skipCountB !== 16'd1) begin
            failCount++;
            $display("[TB] FAIL bypass_off: got exec=%b count=%0d, expected 0/1", execEnB[0], skipCountB);
        end
        assertCount++;
        if (skipCountA !== 16'd0 || statusOutA !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL bypass_on_state: got count=%0d status=%b, expected 0/1000", skipCountA, statusOutA);
        end
    endtask

    task automatic test_ls_le();
        logic [3:0] vFlags [7];
        logic [3:0] vCond0 [7];
        logic [3:0] vCond1 [7];
        logic [1:0] vExec  [7];
        vFlags = '{4'b0000, 4'b1100, 4'b0100, 4'b1000, 4'b0010, 4'b0011, 4'b1111};
        vCond0 = '{4'b1001, 4'b1001, 4'b1001, 4'b1101, 4'b1101, 4'b1101, 4'b1111};
        vCond1 = '{4'b1000, 4'b0000, 4'b1000, 4'b1100, 4'b1011, 4'b1010, 4'b1110};
        vExec  = '{2'b01,   2'b11,   2'b10,   2'b01,   2'b11,   2'b10,   2'b10};
        for (int v = 0; v < 7; v++) begin
            statusWe = 1'b1;
            statusIn = vFlags[v];
            inValid  = 2'b00;
            tick();
            statusWe = 1'b0;
            inValid  = 2'b11;
            cond     = {vCond1[v], vCond0[v]};
            tick();
            assertCount++;
            if (execEnA !== vExec[v] || execEnB !== vExec[v]) begin
                failCount++;
                $display("[TB] FAIL cond_vec%0d: got A=%b B=%b, expected %b", v, execEnA, execEnB, vExec[v]);
            end
        end
        setIdle();
        assertCount++;
        if (skipCountA !== 16'd5 || skipCountB !== 16'd6 || skipCountC !== 4'd5) begin
            failCount++;
            $display("[TB] FAIL cond_count: got A=%0d B=%0d C=%0d, expected 5/6/5", skipCountA, skipCountB, skipCountC);
        end
    endtask

    task automatic test_freeze_flush();
        inValid = 2'b11;
        cond    = {4'b1110, 4'b1110};
        tick();
        freeze = 1'b1;
        cond   = {4'b1111, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            statusWe = (k == 0);
            statusIn = 4'b0101;
            inValid  = (k == 1) ? 2'b00 : 2'b11;
            tick();
            assertCount++;
            if (outValidA !== 2'b11 || execEnA !== 2'b11 || skipCountA !== 16'd5) begin
                failCount++;
                $display("[TB] FAIL freeze_hold%0d: got valid=%b exec=%b count=%0d, expected 11/11/5", k, outValidA, execEnA, skipCountA);
            end
        end
        statusWe = 1'b0;
        assertCount++;
        if (statusOutA !== 4'b0101) begin
            failCount++;
            $display("[TB] FAIL freeze_status: got %b, expected 0101", statusOutA);
        end
        flush   = 1'b1;
        inValid = 2'b11;
        tick();
        setIdle();
        assertCount++;
        if (outValidA !== 2'b00 || execEnA !== 2'b00 || skipCountA !== 16'd5) begin
            failCount++;
            $display("[TB] FAIL flush_kill: got valid=%b exec=%b count=%0d, expected 00/00/5", outValidA, execEnA, skipCountA);
        end
    endtask

    task automatic test_counter();
        countClr = 1'b1;
        inValid  = 2'b01;
        cond     = {4'b1111, 4'b1111};
        tick();
        countClr = 1'b0;
        assertCount++;
        if (skipCountA !== 16'd0 || skipCountC !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL count_clr: got A=%0d C=%0d, expected 0/0", skipCountA, skipCountC);
        end
        inValid = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            assertCount++;
            if (skipCountC !== ((2 * k > 15) ? 4'd15 : 4'(2 * k))) begin
                failCount++;
                $display("[TB] FAIL count_sat%0d: got %0d, expected %0d", k, skipCountC, (2 * k > 15) ? 15 : 2 * k);
            end
        end
        setIdle();
        assertCount++;
        if (skipCountA !== 16'd20) begin
            failCount++;
            $display("[TB] FAIL count_wide: got %0d, expected 20", skipCountA);
        end
    endtask

    task automatic test_reset_mid();
        countClr = 1'b1;
        tick();
        countClr = 1'b0;
        inValid  = 2'b11;
        cond     = {4'b1111, 4'b1111};
        tick();
        tick();
        cond     = {4'b1110, 4'b1111};
        statusWe = 1'b1;
        statusIn = 4'b0011;
        tick();
        assertCount++;
        if (skipCountA !== 16'd5 || outValidA !== 2'b11 || execEnA !== 2'b10 || statusOutA !== 4'b0011) begin
            failCount++;
            $display("[TB] FAIL midrst_setup: got count=%0d valid=%b exec=%b status=%b, expected 5/11/10/0011", skipCountA, outValidA, execEnA, statusOutA);
        end
        rst      = 1'b1;
        statusIn = 4'b1111;
        cond     = {4'b1111, 4'b1111};
        tick();
        rst = 1'b0;
        setIdle();
        assertCount++;
        if (skipCountA !== 16'd0 || outValidA !== 2'b00 || execEnA !== 2'b00 || statusOutA !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL midrst_clear: got count=%0d valid=%b exec=%b status=%b, expected 0/00/00/0000", skipCountA, outValidA, execEnA, statusOutA);
        end
        assertCount++;
        if (skipCountB !== 16'd0 || statusOutB !== 4'b0000 || skipCountC !== 4'd0) begin
            failCount++;
            $display("[TB] FAIL midrst_others: got B=%0d statusB=%b C=%0d, expected 0/0000/0", skipCountB, statusOutB, skipCountC);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b1;
        setIdle();
        test_reset();
        test_basic();
        test_bypass();
        test_ls_le();
        test_freeze_flush();
        test_counter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
